// File: rtl/cpu_host_pkg.sv
// Shared encodings for the host-side command engine that loads, runs and dumps the CPU.
package cpu_host_pkg;

   localparam logic [1:0] OP_LOAD_IMEM = 2'd0;
   localparam logic [1:0] OP_LOAD_DMEM = 2'd1;
   localparam logic [1:0] OP_RUN       = 2'd2;
   localparam logic [1:0] OP_DUMP_DMEM = 2'd3;

   localparam int unsigned WORD_BYTES = 4;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StRun,
      StDumpRd,
      StDumpWait,
      StDumpOut,
      StFinish
   } state_e;

endpackage

// File: rtl/cpu_host_loader.sv
// Host command engine: drives the CPU's external imem/dmem ports and enable input to load
// memories, run the core for a fixed number of cycles, and stream data memory back out.
module cpu_host_loader
   import cpu_host_pkg::*;
#(
   parameter int unsigned LEN_W = 16
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [31:0]      cmd_addr,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic             busy,
   output logic             done,
   output logic             cpu_enable,
   output logic [31:0]      imem_addr,
   output logic             imem_wen,
   output logic             imem_ren,
   output logic [31:0]      imem_wdata,
   input  logic [31:0]      imem_rdata,
   output logic [31:0]      dmem_addr,
   output logic             dmem_wen,
   output logic             dmem_ren,
   output logic [31:0]      dmem_wdata,
   input  logic [31:0]      dmem_rdata
);

   state_e           state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [1:0]       op_q, op_d;

   logic             in_ready_d, out_valid_d, busy_d, done_d, cpu_enable_d;
   logic [31:0]      out_data_d;
   logic [31:0]      imem_addr_d, imem_wdata_d, dmem_addr_d, dmem_wdata_d;
   logic             imem_wen_d, dmem_wen_d, dmem_ren_d;
   logic [31:0]      cmd_base, addr_inc;
   logic             last_q;

   // Instruction memory is never read back by the host.
   logic unused_imem_rdata;
   assign unused_imem_rdata = ^imem_rdata;

   assign cmd_ready = (state_q == StIdle);
   assign imem_ren  = 1'b0;
   assign cmd_base  = cmd_addr & ~32'h3;
   assign addr_inc  = addr_q + 32'(WORD_BYTES);
   assign last_q    = (len_q == LEN_W'(1));

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      len_d        = len_q;
      op_d         = op_q;
      in_ready_d   = 1'b0;
      out_valid_d  = out_valid;
      out_data_d   = out_data;
      done_d       = 1'b0;
      cpu_enable_d = 1'b0;
      imem_addr_d  = imem_addr;
      imem_wdata_d = imem_wdata;
      imem_wen_d   = 1'b0;
      dmem_addr_d  = dmem_addr;
      dmem_wdata_d = dmem_wdata;
      dmem_wen_d   = 1'b0;
      dmem_ren_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               addr_d = cmd_base;
               len_d  = cmd_len;
               op_d   = cmd_op;
               if (cmd_len == '0) begin
                  state_d = StFinish;
               end else begin
                  unique case (cmd_op)
                     OP_LOAD_IMEM, OP_LOAD_DMEM: begin
                        in_ready_d = 1'b1;
                        state_d    = StLoad;
                     end
                     OP_RUN: begin
                        // Enable stays high through FINISH, so RUN itself lasts len-1 cycles.
                        cpu_enable_d = 1'b1;
                        len_d        = cmd_len - LEN_W'(1);
                        state_d      = (cmd_len == LEN_W'(1)) ? StFinish : StRun;
                     end
                     default: begin
                        dmem_ren_d  = 1'b1;
                        dmem_addr_d = cmd_base;
                        state_d     = StDumpRd;
                     end
                  endcase
               end
            end
         end
         StLoad: begin
            in_ready_d = 1'b1;
            if (in_valid) begin
               if (op_q == OP_LOAD_IMEM) begin
                  imem_wen_d   = 1'b1;
                  imem_addr_d  = addr_q;
                  imem_wdata_d = in_data;
               end else begin
                  dmem_wen_d   = 1'b1;
                  dmem_addr_d  = addr_q;
                  dmem_wdata_d = in_data;
               end
               addr_d = addr_inc;
               len_d  = len_q - LEN_W'(1);
               if (last_q) begin
                  in_ready_d = 1'b0;
                  state_d    = StFinish;
               end
            end
         end
         StRun: begin
            cpu_enable_d = 1'b1;
            if (last_q) begin
               state_d = StFinish;
            end else begin
               len_d = len_q - LEN_W'(1);
            end
         end
         StDumpRd: begin
            state_d = StDumpWait;
         end
         StDumpWait: begin
            out_data_d  = dmem_rdata;
            out_valid_d = 1'b1;
            state_d     = StDumpOut;
         end
         StDumpOut: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               addr_d      = addr_inc;
               len_d       = len_q - LEN_W'(1);
               if (last_q) begin
                  state_d = StFinish;
               end else begin
                  dmem_ren_d  = 1'b1;
                  dmem_addr_d = addr_inc;
                  state_d     = StDumpRd;
               end
            end
         end
         StFinish: begin
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         len_q      <= '0;
         op_q       <= '0;
         in_ready   <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         cpu_enable <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         imem_wen   <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         dmem_wen   <= 1'b0;
         dmem_ren   <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         op_q       <= op_d;
         in_ready   <= in_ready_d;
         out_valid  <= out_valid_d;
         out_data   <= out_data_d;
         busy       <= busy_d;
         done       <= done_d;
         cpu_enable <= cpu_enable_d;
         imem_addr  <= imem_addr_d;
         imem_wdata <= imem_wdata_d;
         imem_wen   <= imem_wen_d;
         dmem_addr  <= dmem_addr_d;
         dmem_wdata <= dmem_wdata_d;
         dmem_wen   <= dmem_wen_d;
         dmem_ren   <= dmem_ren_d;
      end
   end

endmodule

// File: tb/tb_cpu_host_loader.sv
// Self-checking bench for cpu_host_loader: command table plus scoreboard queues for writes,
// reads and dump data, with a small data SRAM model behind the dmem port.
module tb_cpu_host_loader;
   import cpu_host_pkg::*;

   logic        clk = 1'b0;
   logic        arst;
   logic        cmd_valid, cmd_ready;
   logic [1:0]  cmd_op;
   logic [31:0] cmd_addr;
   logic [15:0] cmd_len;
   logic        in_valid, in_ready;
   logic [31:0] in_data;
   logic        out_valid, out_ready;
   logic [31:0] out_data;
   logic        busy, done, cpu_enable;
   logic [31:0] imem_addr, imem_wdata, imem_rdata;
   logic        imem_wen, imem_ren;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        dmem_wen, dmem_ren;

   cpu_host_loader #(.LEN_W(16)) dut (
      .clk(clk), .arst(arst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .done(done), .cpu_enable(cpu_enable),
      .imem_addr(imem_addr), .imem_wen(imem_wen), .imem_ren(imem_ren),
      .imem_wdata(imem_wdata), .imem_rdata(imem_rdata),
      .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_ren(dmem_ren),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Data SRAM seen by the DUT (1-cycle read latency) and the bench's own expected image.
   logic [31:0] sram  [256];
   logic [31:0] model [256];
   always @(posedge clk) begin
      if (dmem_wen) sram[dmem_addr[9:2]] <= dmem_wdata;
      if (dmem_ren) dmem_rdata <= sram[dmem_addr[9:2]];
   end

   typedef struct {
      logic [1:0]  sel;
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] addr;
      logic [15:0] len;
      logic [31:0] base;
      int          gap_at;
      int          gap_len;
      int          stall;
   } vec_t;

   wr_t         wr_q [$];
   logic [31:0] rd_q [$];
   logic [31:0] out_q [$];
   vec_t        vecs [11];

   int n_checks = 0;
   int n_pass   = 0;
   int wen_count, ren_count, en_count, done_count, imem_ren_seen;
   int first_en, last_en, last_wen, done_cyc;
   logic        hold_chk = 1'b0;
   logic [31:0] hold_data;
   wr_t         mon_e;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] want);
      n_checks++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, want);
   endfunction

   always @(posedge clk) begin
      hold_chk  <= out_valid && !out_ready && !arst;
      hold_data <= out_data;
   end

   always @(negedge clk) begin
      if (!arst) begin
         if (imem_wen || dmem_wen) begin
            wen_count++;
            last_wen = cyc;
            if (wr_q.size() == 0) begin
               chk("wen_expected", 32'(wr_q.size()), 32'd1);
            end else begin
               mon_e = wr_q.pop_front();
               chk("wen_port", {30'b0, imem_wen, dmem_wen}, {30'b0, mon_e.sel});
               chk("wen_addr", imem_wen ? imem_addr : dmem_addr, mon_e.addr);
               chk("wen_data", imem_wen ? imem_wdata : dmem_wdata, mon_e.data);
            end
         end
         if (dmem_ren) begin
            ren_count++;
            if (rd_q.size() == 0) chk("ren_expected", 32'(rd_q.size()), 32'd1);
            else chk("ren_addr", dmem_addr, rd_q.pop_front());
         end
         if (imem_ren) imem_ren_seen++;
         if (cpu_enable) begin
            if (en_count == 0) first_en = cyc;
            last_en = cyc;
            en_count++;
         end
         if (done) begin
            done_count++;
            done_cyc = cyc;
         end
         if (hold_chk) begin
            chk("out_hold_valid", {31'b0, out_valid}, 32'd1);
            chk("out_hold_data", out_data, hold_data);
         end
      end
   end

   task automatic clear_mon();
      wen_count = 0; ren_count = 0; en_count = 0; done_count = 0;
      first_en = -1; last_en = -1; last_wen = -1; done_cyc = -1;
   endtask

   // Called #1 after a rising edge; returns the cycle index right after the accept edge.
   task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [15:0] len,
                        output int acc);
      int t = 0;
      while (!cmd_ready && t < 50) begin
         @(posedge clk); #1; t++;
      end
      chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_len = len;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      acc = cyc;
      chk("busy_after_accept", {31'b0, busy}, 32'd1);
   endtask

   task automatic wait_done();
      int t = 0;
      while (done_count == 0 && t < 400) begin
         @(negedge clk); t++;
      end
      repeat (3) @(negedge clk);
      chk("done_pulses", 32'(done_count), 32'd1);
      chk("busy_idle", {31'b0, busy}, 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int          acc, t, hs;
      logic        ok;
      logic [31:0] base_a, a, want;
      clear_mon();
      base_a = v.addr & ~32'h3;
      hs = -1;
      if (v.op == OP_DUMP_DMEM) begin
         for (int i = 0; i < int'(v.len); i++) begin
            a = base_a + 32'(4 * i);
            rd_q.push_back(a);
            out_q.push_back(model[a[9:2]]);
         end
      end
      issue(v.op, v.addr, v.len, acc);
      if ((v.op == OP_LOAD_IMEM || v.op == OP_LOAD_DMEM) && v.len != 0) begin
         for (int i = 0; i < int'(v.len); i++) begin
            if (i == v.gap_at) begin
               in_valid = 1'b0;
               repeat (v.gap_len) begin @(posedge clk); #1; end
            end
            a = base_a + 32'(4 * i);
            in_valid = 1'b1;
            in_data  = v.base + 32'(i);
            wr_q.push_back('{(v.op == OP_LOAD_IMEM) ? 2'b10 : 2'b01, a, in_data});
            if (v.op == OP_LOAD_DMEM) model[a[9:2]] = in_data;
            t = 0;
            do begin
               @(negedge clk); ok = in_ready; @(posedge clk); #1; t++;
            end while (!ok && t < 50);
            if (!ok) chk("in_ready_timeout", {31'b0, ok}, 32'd1);
         end
         in_valid = 1'b0;
      end
      if (v.op == OP_DUMP_DMEM && v.len != 0) begin
         for (int w = 0; w < int'(v.len); w++) begin
            t = 0;
            @(negedge clk);
            while (!out_valid && t < 20) begin @(negedge clk); t++; end
            chk("out_valid", {31'b0, out_valid}, 32'd1);
            if (w == 0) repeat (v.stall) @(negedge clk);
            want = out_q.pop_front();
            chk("out_data", out_data, want);
            hs = cyc;
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
         end
      end
      wait_done();

      if (v.len == 0) begin
         chk("len0_done_cycle", 32'(done_cyc), 32'(acc + 1));
         chk("len0_no_wen", 32'(wen_count), 32'd0);
         chk("len0_no_ren", 32'(ren_count), 32'd0);
         chk("len0_no_enable", 32'(en_count), 32'd0);
      end else if (v.op == OP_RUN) begin
         chk("run_first_enable", 32'(first_en), 32'(acc));
         chk("run_last_enable", 32'(last_en), 32'(acc + int'(v.len) - 1));
         chk("run_enable_count", 32'(en_count), 32'(v.len));
         chk("run_done_cycle", 32'(done_cyc), 32'(acc + int'(v.len)));
      end else if (v.op == OP_DUMP_DMEM) begin
         chk("dump_ren_count", 32'(ren_count), 32'(v.len));
         chk("dump_done_cycle", 32'(done_cyc), 32'(hs + 2));
         chk("dump_no_enable", 32'(en_count), 32'd0);
         chk("dump_no_wen", 32'(wen_count), 32'd0);
      end else begin
         chk("load_wen_count", 32'(wen_count), 32'(v.len));
         chk("load_done_cycle", 32'(done_cyc), 32'(last_wen + 1));
         chk("load_no_enable", 32'(en_count), 32'd0);
      end
      chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
      chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
      if (idx < 0) $display("unreachable");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      vecs[0]  = '{OP_LOAD_IMEM, 32'h0000_0000, 16'd3,   32'h0000_000A, -1, 0, 0};
      vecs[1]  = '{OP_LOAD_DMEM, 32'h0000_0010, 16'd2,   32'h0000_000A,  1, 2, 0};
      vecs[2]  = '{OP_RUN,       32'h0000_0000, 16'd5,   32'h0,         -1, 0, 0};
      vecs[3]  = '{OP_DUMP_DMEM, 32'h0000_0010, 16'd2,   32'h0,         -1, 0, 4};
      vecs[4]  = '{OP_LOAD_IMEM, 32'h0000_0040, 16'd0,   32'h0000_00EE, -1, 0, 0};
      vecs[5]  = '{OP_LOAD_IMEM, 32'hFFFF_FFFC, 16'd2,   32'h0000_0011, -1, 0, 0};
      vecs[6]  = '{OP_RUN,       32'h0000_0000, 16'd1,   32'h0,         -1, 0, 0};
      vecs[7]  = '{OP_LOAD_DMEM, 32'h0000_0103, 16'd3,   32'h1234_5600, -1, 0, 0};
      vecs[8]  = '{OP_DUMP_DMEM, 32'h0000_0100, 16'd3,   32'h0,         -1, 0, 0};
      vecs[9]  = '{OP_RUN,       32'h0000_0000, 16'd0,   32'h0,         -1, 0, 0};
      vecs[10] = '{OP_DUMP_DMEM, 32'h0000_0010, 16'd0,   32'h0,         -1, 0, 0};

      for (int i = 0; i < 256; i++) begin
         sram[i]  = 32'h0;
         model[i] = 32'h0;
      end
      imem_rdata = 32'h0;
      arst = 1'b1;
      cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 32'h0; cmd_len = 16'd0;
      in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
      imem_ren_seen = 0;
      clear_mon();

      repeat (2) @(posedge clk); #1;
      chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
      chk("rst_flags", {24'b0, in_ready, out_valid, busy, done, cpu_enable,
                        imem_wen, dmem_wen, dmem_ren}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_imem_addr", imem_addr, 32'd0);
      chk("rst_imem_wdata", imem_wdata, 32'd0);
      chk("rst_dmem_addr", dmem_addr, 32'd0);
      chk("rst_dmem_wdata", dmem_wdata, 32'd0);
      arst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);
      chk("imem_ren_never", 32'(imem_ren_seen), 32'd0);

      // Reset in the middle of a long RUN aborts it with no done.
      clear_mon();
      issue(OP_RUN, 32'h0, 16'd100, acc);
      repeat (10) begin @(posedge clk); #1; end
      chk("run_enable_mid", {31'b0, cpu_enable}, 32'd1);
      #2 arst = 1'b1;
      #1;
      chk("arst_enable_drop", {31'b0, cpu_enable}, 32'd0);
      chk("arst_busy_drop", {31'b0, busy}, 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      arst = 1'b0;
      chk("arst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
      repeat (110) begin @(posedge clk); #1; end
      chk("arst_no_done", 32'(done_count), 32'd0);
      chk("arst_enable_count", 32'(en_count), 32'd10);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
